// File: rtl/usb_debug_pkg.sv
// Shared types and default timing for the USB debug-LED driver.
package usb_debug_pkg;

  typedef enum logic [1:0] {
    LED_OFF     = 2'b00,
    LED_STRETCH = 2'b01,
    LED_STICKY  = 2'b10,
    LED_BLINK   = 2'b11
  } led_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ON    = 2'd1,
    OFF   = 2'd2,
    PAUSE = 2'd3
  } blink_state_t;

  localparam int unsigned DEF_NUM_CH      = 4;
  localparam int unsigned DEF_CLK_FREQ_HZ = 48_000_000;
  localparam int unsigned DEF_STRETCH_MS  = 50;
  localparam int unsigned DEF_BLINK_MS    = 200;
  localparam int unsigned DEF_PAUSE_MS    = 1000;
  localparam int unsigned DEF_MAX_COUNT   = 7;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/usb_debug_led_ch.sv
// One debug-LED channel: saturating event counter, sticky flag, stretch timer,
// count-blink FSM and the registered LED output.
//   state | meaning
//   IDLE  | no burst running; leaves as soon as the counter is nonzero
//   ON    | flash lit for BLINK_MS
//   OFF   | dark gap after a flash for BLINK_MS
//   PAUSE | dark gap after the last flash of a burst for PAUSE_MS
module usb_debug_led_ch
  import usb_debug_pkg::*;
#(
  parameter int unsigned STRETCH_MS = DEF_STRETCH_MS,
  parameter int unsigned BLINK_MS   = DEF_BLINK_MS,
  parameter int unsigned PAUSE_MS   = DEF_PAUSE_MS,
  parameter int unsigned MAX_COUNT  = DEF_MAX_COUNT,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic       clk48,
  input  logic       rst,
  input  logic       ms_tick,
  input  logic       err_pulse,
  input  logic [1:0] mode,
  input  logic       clear,
  output logic       led,
  output logic       err_seen
);

  localparam int unsigned CW = $clog2(MAX_COUNT + 1);
  localparam int unsigned TW = $clog2(STRETCH_MS + 1);
  localparam int unsigned PW = $clog2(max_u(BLINK_MS, PAUSE_MS) + 1);

  led_mode_t     mode_e;
  logic [1:0]    mode_q;
  logic          flush;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] fl_q, fl_d;
  logic          seen_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [PW-1:0] ph_q, ph_d;
  blink_state_t  state_q, state_d;
  logic          led_d;

  assign mode_e = led_mode_t'(mode);
  assign flush  = clear | (mode != mode_q);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) cnt_d = '0;
    if (err_pulse && (cnt_d != CW'(MAX_COUNT))) cnt_d = cnt_d + 1'b1;

    seen_d = err_pulse | (err_seen & ~clear);

    tmr_d = tmr_q;
    if (err_pulse)                   tmr_d = TW'(STRETCH_MS);
    else if (ms_tick && tmr_q != '0) tmr_d = tmr_q - 1'b1;
    if (flush) tmr_d = '0;

    state_d = state_q;
    ph_d    = ph_q;
    fl_d    = fl_q;
    if (mode_e == LED_BLINK) begin
      case (state_q)
        IDLE: if (cnt_d != '0) begin
          state_d = ON;
          ph_d    = PW'(BLINK_MS);
          fl_d    = cnt_d;
        end
        ON: if (ms_tick) begin
          if (ph_q == PW'(1)) begin
            state_d = OFF;
            ph_d    = PW'(BLINK_MS);
          end else ph_d = ph_q - 1'b1;
        end
        OFF: if (ms_tick) begin
          if (ph_q == PW'(1)) begin
            if (fl_q > CW'(1)) begin
              state_d = ON;
              ph_d    = PW'(BLINK_MS);
              fl_d    = fl_q - 1'b1;
            end else begin
              state_d = PAUSE;
              ph_d    = PW'(PAUSE_MS);
            end
          end else ph_d = ph_q - 1'b1;
        end
        PAUSE: if (ms_tick) begin
          // Pass through IDLE in zero cycles so bursts repeat on a fixed period.
          if (ph_q == PW'(1)) begin
            if (cnt_d != '0) begin
              state_d = ON;
              ph_d    = PW'(BLINK_MS);
              fl_d    = cnt_d;
            end else begin
              state_d = IDLE;
              ph_d    = '0;
            end
          end else ph_d = ph_q - 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
    if (flush) begin
      state_d = IDLE;
      ph_d    = '0;
      fl_d    = '0;
    end

    case (mode_e)
      LED_STRETCH: led_d = (tmr_d != '0);
      LED_STICKY:  led_d = seen_d;
      LED_BLINK:   led_d = (state_d == ON);
      default:     led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk48) begin
    mode_q <= mode;
  end

  always_ff @(posedge clk48) begin
    if (rst) begin
      cnt_q    <= '0;
      err_seen <= 1'b0;
      tmr_q    <= '0;
      state_q  <= IDLE;
      ph_q     <= '0;
      fl_q     <= '0;
      led      <= ACTIVE_LOW;
    end else begin
      cnt_q    <= cnt_d;
      err_seen <= seen_d;
      tmr_q    <= tmr_d;
      state_q  <= state_d;
      ph_q     <= ph_d;
      fl_q     <= fl_d;
      led      <= led_d ^ ACTIVE_LOW;
    end
  end

endmodule

// File: rtl/usb_debug_led_ctrl.sv
// Debug-LED driver for the USB device controller: shared ms prescaler feeding
// NUM_CH independent LED channels with runtime-selectable display modes.
module usb_debug_led_ctrl
  import usb_debug_pkg::*;
#(
  parameter int unsigned NUM_CH      = DEF_NUM_CH,
  parameter int unsigned CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int unsigned STRETCH_MS  = DEF_STRETCH_MS,
  parameter int unsigned BLINK_MS    = DEF_BLINK_MS,
  parameter int unsigned PAUSE_MS    = DEF_PAUSE_MS,
  parameter int unsigned MAX_COUNT   = DEF_MAX_COUNT,
  parameter bit          ACTIVE_LOW  = 1'b0
) (
  input  logic                clk48,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   err_pulse,
  input  logic [2*NUM_CH-1:0] ch_mode,
  input  logic                clear,
  output logic [NUM_CH-1:0]   led_o,
  output logic [NUM_CH-1:0]   err_seen
);

  localparam int unsigned DIV = CLK_FREQ_HZ / 1000;
  localparam int unsigned PSW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PSW-1:0] presc_q;
  logic           ms_tick;

  assign ms_tick = (presc_q == PSW'(DIV - 1));

  // Free-running; clear deliberately leaves the ms phase alone.
  always_ff @(posedge clk48) begin
    if (rst || ms_tick) presc_q <= '0;
    else                presc_q <= presc_q + 1'b1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    usb_debug_led_ch #(
      .STRETCH_MS(STRETCH_MS),
      .BLINK_MS  (BLINK_MS),
      .PAUSE_MS  (PAUSE_MS),
      .MAX_COUNT (MAX_COUNT),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_ch (
      .clk48    (clk48),
      .rst      (rst),
      .ms_tick  (ms_tick),
      .err_pulse(err_pulse[i]),
      .mode     (ch_mode[2*i +: 2]),
      .clear    (clear),
      .led      (led_o[i]),
      .err_seen (err_seen[i])
    );
  end

endmodule

// File: tb/tb_usb_debug_led_ctrl.sv
// Scoreboard bench: the driver pushes model predictions, the monitor compares
// both an active-high and an active-low build against them every cycle.
module tb_usb_debug_led_ctrl;

  localparam int NUM_CH      = 4;
  localparam int CLK_FREQ_HZ = 8000;
  localparam int STRETCH_MS  = 3;
  localparam int BLINK_MS    = 2;
  localparam int PAUSE_MS    = 5;
  localparam int MAX_COUNT   = 3;
  localparam int DIV         = CLK_FREQ_HZ / 1000;

  logic       clk48 = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] err_pulse = '0;
  logic [7:0] ch_mode = '0;
  logic       clear = 1'b0;
  logic [3:0] led_o, err_seen, led_o_n, err_seen_n;

  always #5 clk48 = ~clk48;

  usb_debug_led_ctrl #(
    .NUM_CH(NUM_CH), .CLK_FREQ_HZ(CLK_FREQ_HZ), .STRETCH_MS(STRETCH_MS),
    .BLINK_MS(BLINK_MS), .PAUSE_MS(PAUSE_MS), .MAX_COUNT(MAX_COUNT), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk48(clk48), .rst(rst), .err_pulse(err_pulse), .ch_mode(ch_mode),
    .clear(clear), .led_o(led_o), .err_seen(err_seen)
  );

  usb_debug_led_ctrl #(
    .NUM_CH(NUM_CH), .CLK_FREQ_HZ(CLK_FREQ_HZ), .STRETCH_MS(STRETCH_MS),
    .BLINK_MS(BLINK_MS), .PAUSE_MS(PAUSE_MS), .MAX_COUNT(MAX_COUNT), .ACTIVE_LOW(1'b1)
  ) dut_n (
    .clk48(clk48), .rst(rst), .err_pulse(err_pulse), .ch_mode(ch_mode),
    .clear(clear), .led_o(led_o_n), .err_seen(err_seen_n)
  );

  typedef struct packed {
    logic [3:0] led;
    logic [3:0] seen;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model: ms arithmetic on elapsed time, not a state machine.
  int         m_cyc;
  int         m_cnt[NUM_CH];
  bit         m_seen[NUM_CH];
  int         m_light_ms[NUM_CH];
  bit         m_burst[NUM_CH];
  int         m_elapsed[NUM_CH];
  int         m_flashes[NUM_CH];
  logic [1:0] m_prev[NUM_CH];

  task automatic model_step(input logic r, input logic [3:0] p, input logic [7:0] m,
                            input logic c, output exp_t e);
    bit tick, flush, on;
    logic [1:0] md;
    int period;
    e = '0;
    if (r) begin
      m_cyc = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_cnt[i] = 0; m_seen[i] = 0; m_light_ms[i] = 0;
        m_burst[i] = 0; m_elapsed[i] = 0; m_flashes[i] = 0;
        m_prev[i] = m[2*i +: 2];
      end
      return;
    end
    tick = ((m_cyc % DIV) == DIV - 1);
    m_cyc++;
    for (int i = 0; i < NUM_CH; i++) begin
      md = m[2*i +: 2];
      flush = c || (md != m_prev[i]);
      m_prev[i] = md;
      if (c) m_cnt[i] = 0;
      if (p[i] && m_cnt[i] < MAX_COUNT) m_cnt[i]++;
      if (p[i]) m_seen[i] = 1;
      else if (c) m_seen[i] = 0;
      if (p[i]) m_light_ms[i] = STRETCH_MS;
      else if (tick && m_light_ms[i] > 0) m_light_ms[i]--;
      if (flush) m_light_ms[i] = 0;
      if (flush || md != 2'b11) m_burst[i] = 0;
      else if (!m_burst[i]) begin
        if (m_cnt[i] > 0) begin
          m_burst[i] = 1; m_elapsed[i] = 0; m_flashes[i] = m_cnt[i];
        end
      end else if (tick) begin
        m_elapsed[i]++;
        period = 2 * m_flashes[i] * BLINK_MS + PAUSE_MS;
        if (m_elapsed[i] == period) begin
          if (m_cnt[i] > 0) begin
            m_elapsed[i] = 0; m_flashes[i] = m_cnt[i];
          end else m_burst[i] = 0;
        end
      end
      case (md)
        2'b00:   on = 0;
        2'b01:   on = (m_light_ms[i] > 0);
        2'b10:   on = m_seen[i];
        default: on = m_burst[i] && (m_elapsed[i] < 2 * m_flashes[i] * BLINK_MS)
                      && ((m_elapsed[i] / BLINK_MS) % 2 == 0);
      endcase
      e.led[i]  = on;
      e.seen[i] = m_seen[i];
    end
  endtask

  task automatic step(input logic r, input logic [3:0] p, input logic [7:0] m, input logic c);
    exp_t e;
    @(negedge clk48);
    rst = r; err_pulse = p; ch_mode = m; clear = c;
    model_step(r, p, m, c, e);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic [7:0] m);
    repeat (n) step(1'b0, 4'h0, m, 1'b0);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk48);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("led_o", led_o, e.led);
        check("err_seen", err_seen, e.seen);
        check("led_o_active_low", led_o_n, ~e.led);
        check("err_seen_active_low", err_seen_n, e.seen);
      end
    end
  end

  initial begin : driver
    logic [7:0] md;
    logic [3:0] p;
    logic       c, r;
    int         j, waited;
    md = 8'hF9;  // ch0 stretch, ch1 sticky, ch2 blink, ch3 blink
    repeat (3) step(1'b1, 4'hF, md, 1'b0);
    idle(7, md);
    // stretch with retrigger
    step(1'b0, 4'b0001, md, 1'b0); idle(9, md);
    step(1'b0, 4'b0001, md, 1'b0); idle(40, md);
    // sticky, clear, clear racing a pulse
    step(1'b0, 4'b0010, md, 1'b0); idle(20, md);
    step(1'b0, 4'b0000, md, 1'b1); idle(5, md);
    step(1'b0, 4'b0010, md, 1'b0); idle(3, md);
    step(1'b0, 4'b0010, md, 1'b1); idle(5, md);
    // count-blink: load two events with ch2 off, then enable
    md = 8'hC9;
    step(1'b0, 4'b0000, md, 1'b1);
    step(1'b0, 4'b0100, md, 1'b0); idle(3, md);
    step(1'b0, 4'b0100, md, 1'b0); idle(2, md);
    md = 8'hF9; idle(250, md);
    // five events saturate to three flashes
    md = 8'hC9;
    step(1'b0, 4'b0000, md, 1'b1);
    repeat (5) begin step(1'b0, 4'b0100, md, 1'b0); idle(1, md); end
    md = 8'hF9; idle(250, md);
    // ch3: leave blink mid-ON, then return and count flashes
    step(1'b0, 4'b1000, md, 1'b0); idle(2, md);
    step(1'b0, 4'b1000, md, 1'b0); idle(4, md);
    md[7:6] = 2'b01; idle(30, md);
    md[7:6] = 2'b11; idle(250, md);
    // randomized traffic
    for (int k = 0; k < 2000; k++) begin
      for (int i = 0; i < NUM_CH; i++) p[i] = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 99) == 0) begin
        j = $urandom_range(0, 3);
        md[2*j +: 2] = 2'($urandom_range(0, 3));
      end
      c = ($urandom_range(0, 199) == 0);
      r = ($urandom_range(0, 1499) == 0);
      step(r, p, md, c);
    end
    idle(2, md);
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk48);
      waited++;
    end
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
